// File: rtl/de_norton.sv
// Norton transceiver for one analog pin: solves V=(Idrv+Iext)/(Gdrv+Gext), reports V and own delivered current.
// Latency: accept at edge k -> out_valid pulse after edge k+IW+3 (1 setup, IW+1 divide, 1 finish cycle).
// Backpressure: in_ready low while solving; in_valid ignored when busy; ready again in the out_valid cycle.
module de_norton #(
    parameter int IW = 32,
    parameter int GW = 24,
    parameter int VW = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] idrv,
    input  logic [GW-1:0] gdrv,
    input  logic [IW-1:0] ext_i,
    input  logic [GW-1:0] ext_g,
    output logic [VW-1:0] vobs,
    output logic [IW-1:0] iobs,
    output logic          floating,
    output logic          out_valid
);

    localparam int PW = IW + GW + VW;
    localparam int CW = $clog2(IW + 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(IW + 1);
    // Largest magnitudes representable in the signed voltage word.
    localparam logic [IW:0] NEG_LIM = (IW+1)'(1) << (VW - 1);
    localparam logic [IW:0] POS_LIM = NEG_LIM - (IW+1)'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW:0]   n_q, n_d;          // signed numerator Idrv+Iext
    logic [GW:0]   d_q, d_d;          // unsigned denominator Gdrv+Gext
    logic [IW-1:0] idrv_q, idrv_d;
    logic [GW-1:0] gdrv_q, gdrv_d;
    logic          neg_q, neg_d;
    logic [IW:0]   quo_q, quo_d;      // dividend shifted out, quotient shifted in
    logic [GW+1:0] rem_q, rem_d;
    logic [VW-1:0] vobs_q, vobs_d;
    logic [IW-1:0] iobs_q, iobs_d;
    logic          floating_q, floating_d;
    logic          out_valid_q, out_valid_d;

    logic [GW+2:0]          rem_sh;
    logic                   rem_ge;
    logic [VW-1:0]          q_sat;
    logic signed [PW-1:0]   gprod;
    logic signed [PW-1:0]   i_full;
    logic [IW-1:0]          i_sat;

    // Finish-stage arithmetic: signed, saturated voltage and the delivered current.
    always_comb begin
        q_sat = '0;
        if (d_q == '0) begin
            q_sat = '0;
        end else if (!neg_q) begin
            q_sat = (quo_q > POS_LIM) ? {1'b0, {(VW-1){1'b1}}} : quo_q[VW-1:0];
        end else begin
            q_sat = (quo_q > NEG_LIM) ? {1'b1, {(VW-1){1'b0}}}
                                      : ({VW{1'b0}} - quo_q[VW-1:0]);
        end
        gprod  = $signed({{(PW-GW){1'b0}}, gdrv_q}) * $signed({{(PW-VW){q_sat[VW-1]}}, q_sat});
        i_full = $signed({{(PW-IW){idrv_q[IW-1]}}, idrv_q}) - gprod;
        i_sat  = i_full[IW-1:0];
        if (!(&i_full[PW-1:IW-1]) && (|i_full[PW-1:IW-1])) begin
            i_sat = i_full[PW-1] ? {1'b1, {(IW-1){1'b0}}} : {1'b0, {(IW-1){1'b1}}};
        end
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_sh = {rem_q, quo_q[IW]};
        rem_ge = (rem_sh >= {2'b00, d_q});
    end

    // Control FSM and datapath next-state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        d_d         = d_q;
        idrv_d      = idrv_q;
        gdrv_d      = gdrv_q;
        neg_d       = neg_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        vobs_d      = vobs_q;
        iobs_d      = iobs_q;
        floating_d  = floating_q;
        out_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    n_d     = {idrv[IW-1], idrv} + {ext_i[IW-1], ext_i};
                    d_d     = {1'b0, gdrv} + {1'b0, ext_g};
                    idrv_d  = idrv;
                    gdrv_d  = gdrv;
                    cnt_d   = '0;
                    state_d = ST_DIV;
                end
            end
            ST_DIV: begin
                if (cnt_q == '0) begin
                    // Setup cycle: take the magnitude of the numerator.
                    neg_d = n_q[IW];
                    quo_d = n_q[IW] ? ({(IW+1){1'b0}} - n_q) : n_q;
                    rem_d = '0;
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    rem_d = rem_ge ? (rem_sh[GW+1:0] - {1'b0, d_q}) : rem_sh[GW+1:0];
                    quo_d = {quo_q[IW-1:0], rem_ge};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                vobs_d      = q_sat;
                iobs_d      = i_sat;
                floating_d  = (d_q == '0);
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any solve in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            d_q         <= '0;
            idrv_q      <= '0;
            gdrv_q      <= '0;
            neg_q       <= 1'b0;
            quo_q       <= '0;
            rem_q       <= '0;
            vobs_q      <= '0;
            iobs_q      <= '0;
            floating_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            d_q         <= d_d;
            idrv_q      <= idrv_d;
            gdrv_q      <= gdrv_d;
            neg_q       <= neg_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            vobs_q      <= vobs_d;
            iobs_q      <= iobs_d;
            floating_q  <= floating_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign vobs      = vobs_q;
    assign iobs      = iobs_q;
    assign floating  = floating_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_de_norton.sv
// Directed bench for de_norton: table of solves plus back-to-back, busy and reset sequences.
module tb_de_norton;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] idrv;
    logic        [23:0] gdrv;
    logic signed [31:0] ext_i;
    logic        [23:0] ext_g;
    logic signed [23:0] vobs;
    logic signed [31:0] iobs;
    logic               floating;
    logic               out_valid;

    always #5 clk = ~clk;

    de_norton dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .idrv     (idrv),
        .gdrv     (gdrv),
        .ext_i    (ext_i),
        .ext_g    (ext_g),
        .vobs     (vobs),
        .iobs     (iobs),
        .floating (floating),
        .out_valid(out_valid)
    );

    typedef struct packed {
        logic signed [31:0] idrv;
        logic        [23:0] gdrv;
        logic signed [31:0] ext_i;
        logic        [23:0] ext_g;
        logic signed [23:0] v;
        logic signed [31:0] i;
        logic               f;
    } vec_t;

    vec_t tbl [6];
    vec_t th_a, th_b;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic scramble();
        idrv  = $urandom;
        gdrv  = 24'($urandom);
        ext_i = $urandom;
        ext_g = 24'($urandom);
    endtask

    // Called at a negedge: present a request, let the next rising edge accept it.
    task automatic start(input vec_t v, input string tag);
        idrv     = v.idrv;
        gdrv     = v.gdrv;
        ext_i    = v.ext_i;
        ext_g    = v.ext_g;
        in_valid = 1'b1;
        chk({tag, "_ready"}, longint'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        scramble();
    endtask

    // Wait for the result; optionally poke in_valid with junk while busy.
    task automatic finish(input vec_t v, input string tag, input int poke_at);
        int cyc;
        bit busy_bad;
        cyc      = 0;
        busy_bad = 1'b0;
        while (!out_valid && cyc < 100) begin
            if (in_ready) busy_bad = 1'b1;
            if (poke_at > 0 && cyc == poke_at) begin
                in_valid = 1'b1;
                idrv     = 32'sd5;
                gdrv     = 24'd0;
                ext_i    = 32'sd0;
                ext_g    = 24'd1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, longint'(cyc), 35);
        chk({tag, "_busy_ready"}, longint'(busy_bad), 0);
        chk({tag, "_vobs"}, longint'(vobs), longint'(v.v));
        chk({tag, "_iobs"}, longint'(iobs), longint'(v.i));
        chk({tag, "_floating"}, longint'(floating), longint'(v.f));
    endtask

    initial begin
        int ov;
        tbl[0] = '{-32'sd10000, 24'd0, 32'sd0, 24'd100, -24'sd100, -32'sd10000, 1'b0};
        tbl[1] = '{32'sd1800000, 24'd1000, 32'sd0, 24'd1000, 24'sd900, 32'sd900000, 1'b0};
        tbl[2] = '{32'sd5, 24'd0, 32'sd0, 24'd0, 24'sd0, 32'sd5, 1'b1};
        tbl[3] = '{32'sd5, 24'd0, 32'sd0, 24'd1, 24'sd5, 32'sd5, 1'b0};
        tbl[4] = '{32'sd2147483647, 24'd1, 32'sd0, 24'd0, 24'sd8388607, 32'sd2139095040, 1'b0};
        tbl[5] = '{32'sh80000000, 24'd0, 32'sh80000000, 24'd1, 24'sh800000, 32'sh80000000, 1'b0};
        th_a   = tbl[1];
        th_b   = '{-32'sd7, 24'd2, 32'sd0, 24'd0, -24'sd3, -32'sd1, 1'b0};

        // Reset with random operands on the inputs.
        rst_n    = 1'b0;
        in_valid = 1'b0;
        scramble();
        repeat (3) @(negedge clk);
        chk("rst_vobs", longint'(vobs), 0);
        chk("rst_iobs", longint'(iobs), 0);
        chk("rst_floating", longint'(floating), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
        rst_n = 1'b1;
        ov = 0;
        repeat (50) begin
            @(negedge clk);
            if (out_valid) ov++;
        end
        chk("idle_no_out_valid", longint'(ov), 0);

        // Table of independent solves.
        for (int i = 0; i < 6; i++) begin
            start(tbl[i], $sformatf("v%0d", i));
            finish(tbl[i], $sformatf("v%0d", i), 0);
            @(negedge clk);
            chk($sformatf("v%0d_pulse", i), longint'(out_valid), 0);
        end

        // Back-to-back: second request issued in the out_valid cycle.
        start(th_a, "b2b_a");
        finish(th_a, "b2b_a", 0);
        start(th_b, "b2b_b");
        finish(th_b, "b2b_b", 0);
        @(negedge clk);

        // in_valid pulsed with new operands mid-divide must be ignored.
        start(th_a, "busy");
        finish(th_a, "busy", 10);
        @(negedge clk);

        // Reset 10 cycles after accept aborts the solve.
        start(tbl[0], "abort");
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_vobs", longint'(vobs), 0);
        chk("abort_iobs", longint'(iobs), 0);
        chk("abort_floating", longint'(floating), 0);
        chk("abort_in_ready", longint'(in_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ov = 0;
        repeat (50) begin
            @(negedge clk);
            if (out_valid) ov++;
        end
        chk("abort_no_out_valid", longint'(ov), 0);
        chk("abort_ready_after", longint'(in_ready), 1);
        chk("abort_vobs_after", longint'(vobs), 0);

        // Recovery solve after the aborted one.
        start(tbl[0], "recover");
        finish(tbl[0], "recover", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/de_norton.md
Name: de_norton

Overview:
- Synthesizable fixed-point discrete-electrical (DE) Norton transceiver for one analog pin.
- The block holds its own Norton driver: current Idrv in parallel with conductance Gdrv. It also takes the summed Norton contributions of all other drivers on the same net.
- It solves the node voltage V = (Idrv + Iext)/(Gdrv + Gext) with a sequential divider.
- It reports the observed voltage Vobs and the observed current Iobs = Idrv − Gdrv·V delivered into the node. Behavioural models use it to drive and observe supply, ground and bias-current pins.

Parameters:
- IW, 32, width of signed current words; LSB = 1 nA.
- GW, 24, width of unsigned conductance words; LSB = 1 uS.
- VW, 24, width of signed voltage word; LSB = 1 mV (nA/uS = mV, uS·mV = nA).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request a new solve with the current operands.
- in_ready  out  1  block idle, can accept a request.
- idrv  in  IW  own Norton current, signed. Positive means current injected into the node.
- gdrv  in  GW  own Norton conductance, unsigned.
- ext_i  in  IW  sum of the other drivers' Norton currents, signed.
- ext_g  in  GW  sum of the other drivers' conductances, unsigned.
- vobs  out  VW  solved node voltage, signed, registered.
- iobs  out  IW  current this driver delivers into the node, signed, registered.
- floating  out  1  node had zero total conductance at the last solve.
- out_valid  out  1  one-cycle pulse when vobs/iobs/floating update.

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - vobs=0, iobs=0, floating=0, out_valid=0.
  - in_ready=1; internal state goes to IDLE.
- States: IDLE, DIV, FIN.
- Accept:
  - A request is accepted on a rising edge where in_valid=1 and in_ready=1.
  - On accept, capture N = idrv+ext_i as IW+1 signed bits (no overflow), D = gdrv+ext_g as GW+1 bits, and a copy of idrv and gdrv.
  - Go to DIV; in_ready=0.
- DIV:
  - Restoring unsigned division of |N| by D, one quotient bit per cycle, IW+1 cycles.
  - If D=0, the divider still runs for the same number of cycles; the result is forced in FIN.
- FIN (one cycle):
  - q = sign(N)·(|N| div D), i.e. truncation toward zero.
  - Saturate q to the signed VW range [−2^(VW−1), 2^(VW−1)−1].
  - If D=0: q=0 and floating=1; otherwise floating=0.
  - iobs = idrv − gdrv·q, computed at full width (IW+GW+VW), then saturated to the signed IW range.
  - vobs=q. Registers update on the FIN→IDLE edge together with out_valid=1 for exactly one cycle.
- Latency: accept at edge k → out_valid high after edge k+IW+3 (35 cycles for IW=32).
- in_ready is 1 in the same cycle out_valid is 1, so back-to-back requests are allowed.
- in_valid while busy is ignored. No queuing; operands are not re-sampled.
- Operand inputs may change freely after accept.
- Outputs hold their last values between solves.
- Reset mid-solve aborts the solve: no out_valid, outputs go to their reset values, and in_ready=1 after release.

Test Plan:
- Reset:
  - Stimulus: hold rst_n=0 with random operands.
  - Required: vobs=0, iobs=0, floating=0, out_valid=0, in_ready=1.
  - After release with in_valid=0: no out_valid ever.
- Bias sink into resistor:
  - Stimulus: idrv=−10000, gdrv=0, ext_i=0, ext_g=100.
  - Required: vobs=−100, iobs=−10000, floating=0.
  - out_valid exactly 35 cycles after accept, in_ready low for those cycles.
- Thevenin divider:
  - Stimulus: idrv=1800000, gdrv=1000, ext_i=0, ext_g=1000.
  - Required: vobs=900, iobs=900000.
  - Second case, issued back-to-back on the out_valid cycle: idrv=−7, gdrv=2, ext_g=0. Required: vobs=−3 (truncation toward zero), iobs=−1.
- Floating node:
  - Stimulus: idrv=5, gdrv=0, ext_i=0, ext_g=0.
  - Required: vobs=0, iobs=5, floating=1.
  - A following solve with ext_g=1 clears floating and gives vobs=5, iobs=5.
- Saturation:
  - Stimulus: idrv=2147483647, gdrv=1, ext_i=0, ext_g=0.
  - Required: vobs=8388607, iobs=2139095040.
  - Stimulus: idrv=−2147483648, gdrv=0, ext_i=−2147483648, ext_g=1.
  - Required: vobs=−8388608, iobs=−2147483648.
- Busy/reset robustness:
  - Pulse in_valid with new operands mid-DIV. Required: ignored; the result matches the originally accepted operands.
  - Drop rst_n 10 cycles after an accept. Required: no out_valid, outputs=0, in_ready=1 after release.
